serial_adder: RTL
=================

Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit operand pair DIGIT bits per clock through one internal DIGIT-bit ripple-carry slice built from full-adder cells.
- Uses a start/busy/done handshake. Trades latency for area in lab datapaths that need wide adds without a full-width combinational carry chain.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.
- DIGIT, 1, bits added per clock; must divide WIDTH exactly. N = WIDTH/DIGIT is the number of compute cycles.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation. Sampled on rising clk.
- a  input  WIDTH  operand A, captured when start is accepted.
- b  input  WIDTH  operand B, captured when start is accepted.
- c_in  input  1  carry-in for addition. Ignored when sub=1.
- sub  input  1  0: sum = a + b + c_in. 1: sum = a - b (computed as a + ~b + 1). Captured with the operands.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result. Holds until the next accepted start.
- c_out  output  1  carry out of the MSB. For subtraction, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is asynchronous and active-high. While rst=1: state=IDLE, count=0, busy=0, done=0, sum=0, c_out=0, ovf=0, internal carry=0, operand registers=0.
  - Reset asserted mid-operation aborts the operation immediately. No done pulse follows.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at the rising edge: latch a, b (inverted if sub), sub and the initial carry (c_in, or 1 if sub).
  - Clear sum. Set count=0. Go to RUN.
- RUN:
  - Each edge adds digit[count] of A and B plus the carry register.
  - Writes the DIGIT-bit result into sum bits [count*DIGIT +: DIGIT] and updates the carry register.
  - On the edge processing digit N-1: register c_out, compute ovf from the MSB carry-in and carry-out, go to DONE.
  - start is ignored in RUN. Operands a, b, c_in, sub may change freely without effect.
- DONE:
  - done=1 for exactly this one cycle. sum, c_out and ovf are valid.
  - Next edge: if start=1, accept a new operation exactly as in IDLE (back-to-back). Otherwise go to IDLE.
- Latency: start sampled at edge k gives busy=1 from k to k+N, and done=1 in the cycle after edge k+N. Back-to-back throughput is one operation per N+1 cycles.
- Partial results: sum bits change during RUN. Only the value present while done=1, or later while idle, is a guaranteed result.
- Arithmetic: all arithmetic is modulo 2^WIDTH. ovf uses two's-complement interpretation for both add and sub.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro SERIAL_ADDER_ACCUM_EN.
- When defined:
  - Adds input port acc (1 bit).
  - If acc=1 when start is accepted, operand A is taken from the current sum register instead of port a. This gives a running accumulate/decrement.
  - acc=0 behaves exactly as the base design.
- When undefined: no acc port, and operand A always comes from port a.

Test Plan:
- WIDTH=8, DIGIT=1, a=0x5A, b=0x3C, c_in=0, sub=0, start pulse → busy high 8 cycles; done pulse with sum=0x96, c_out=0, ovf=1.
- WIDTH=8, DIGIT=1, a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1, ovf=0. Repeat with a=0x00, b=0x00, c_in=1 → sum=0x01, c_out=0.
- sub=1, a=0x10, b=0x20 → sum=0xF0, c_out=0, ovf=0. Then a=0x80, b=0x01 → sum=0x7F, c_out=1, ovf=1.
- WIDTH=16, DIGIT=4, a=0x1234, b=0x0FFF → done exactly 4 cycles after the start edge, sum=0x2233. Hold start high continuously → done pulses every 5 cycles.
- start pulsed again during RUN with different operands → ignored; the original result is delivered. Assert rst for 1 cycle mid-RUN → busy=0, done=0, sum=0 immediately; no done pulse afterwards.
- With SERIAL_ADDER_ACCUM_EN: a=0x05 add 0x03 → 0x08. Then acc=1, b=0x03 → 0x0B. Then acc=1, sub=1, b=0x0B → 0x00, c_out=1.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle adder/subtractor. A WIDTH-bit operand pair is consumed DIGIT
//   bits per clock through a single DIGIT-bit ripple-carry slice, so a full
//   operation takes N = WIDTH/DIGIT compute cycles plus one DONE cycle.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits processed per clock (must divide WIDTH)
//
// Ports
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   start  request a new operation (ignored while busy)
//   a, b   operands, captured when start is accepted
//   c_in   carry-in for addition (ignored when sub=1)
//   sub    1 = a - b, 0 = a + b + c_in
//   busy   high while digits are being processed
//   done   one-cycle pulse, result valid
//   sum    result, held until the next accepted start
//   c_out  carry out of the MSB (for subtraction 1 = no borrow)
//   ovf    two's-complement overflow
//
// Optional build macro SERIAL_ADDER_ACCUM_EN adds port acc: when acc=1 at
// an accepted start, operand A is taken from the current sum instead of a.

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
`ifdef SERIAL_ADDER_ACCUM_EN
  input  logic             acc,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] aReg_q, aReg_d;
  logic [WIDTH-1:0] bReg_q, bReg_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cOut_q, cOut_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] opA;
  logic [DIGIT-1:0] sliceSum;
  logic [DIGIT:0]   carryChain;

  // Accumulate mode feeds the running result back in as operand A.
`ifdef SERIAL_ADDER_ACCUM_EN
  assign opA = acc ? sum_q : a;
`else
  assign opA = a;
`endif

  // One DIGIT-bit ripple slice of full adders. The operand registers shift
  // right each cycle, so the current digit is always in the low bits.
  always_comb begin
    carryChain    = '0;
    sliceSum      = '0;
    carryChain[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      sliceSum[i]     = aReg_q[i] ^ bReg_q[i] ^ carryChain[i];
      carryChain[i+1] = (aReg_q[i] & bReg_q[i]) |
                        (carryChain[i] & (aReg_q[i] ^ bReg_q[i]));
    end
  end

  // Next-state and datapath updates. Subtraction is folded into the
  // captured operands (inverted B, carry-in forced to 1), so the RUN
  // state does not need to remember the operation.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    aReg_d  = aReg_q;
    bReg_d  = bReg_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cOut_d  = cOut_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          aReg_d  = opA;
          bReg_d  = sub ? ~b : b;
          carry_d = sub | c_in;
          sum_d   = '0;
          count_d = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sum_d[int'(count_q) * DIGIT +: DIGIT] = sliceSum;
        carry_d = carryChain[DIGIT];
        aReg_d  = aReg_q >> DIGIT;
        bReg_d  = bReg_q >> DIGIT;
        if (count_q == LAST) begin
          // carryChain[DIGIT-1] is the carry into the result MSB here.
          cOut_d  = carryChain[DIGIT];
          ovf_d   = carryChain[DIGIT] ^ carryChain[DIGIT-1];
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      aReg_q  <= '0;
      bReg_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cOut_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      aReg_q  <= aReg_d;
      bReg_q  <= bReg_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cOut_q  <= cOut_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = cOut_q;
  assign ovf   = ovf_q;

endmodule
